// File: rtl/jsv_pio_in_edge.sv
// jsv_pio_in_edge: Avalon-MM input port with synchroniser, optional debounce,
// per-bit edge capture, maskable level IRQ and an edge-event counter.
`default_nettype none

module jsv_pio_in_edge #(
    parameter int WIDTH     = 3,
    parameter int DEBOUNCE  = 0,
    parameter int EDGE_TYPE = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_COUNT = 2'd1;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGE  = 2'd3;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] filtered;
    logic [WIDTH-1:0] filtered_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] w1c_bits;
    logic [CNT_W-1:0] count;
    logic             wr_en;
    logic             any_edge;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    generate
        if (DEBOUNCE > 0) begin : g_debounce
            localparam int DB_W = $clog2(DEBOUNCE + 1);
            localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

            logic [DB_W-1:0] db_cnt [WIDTH];

            // A bit is only accepted after it has disagreed with filtered for DEBOUNCE cycles in a row.
            always_ff @(posedge clk) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (reset) begin
                        db_cnt[i]   <= '0;
                        filtered[i] <= 1'b0;
                    end else if (sync2[i] == filtered[i]) begin
                        db_cnt[i] <= '0;
                    end else if (db_cnt[i] == DB_LAST) begin
                        filtered[i] <= sync2[i];
                        db_cnt[i]   <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end
            end
        end else begin : g_no_debounce
            always_ff @(posedge clk) begin
                if (reset) begin
                    filtered <= '0;
                end else begin
                    filtered <= sync2;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            filtered_d <= '0;
        end else begin
            filtered_d <= filtered;
        end
    end

    assign rise = filtered & ~filtered_d;
    assign fall = ~filtered & filtered_d;

    always_comb begin
        case (EDGE_TYPE)
            0:       edges = rise;
            1:       edges = fall;
            default: edges = rise | fall;
        endcase
    end

    assign any_edge = |edges;
    assign wr_en    = chipselect & ~write_n;
    assign w1c_bits = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    // Set is OR-ed in after the clear so a same-cycle edge always survives W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            edgecapture <= '0;
            irqmask     <= '0;
            count       <= '0;
            irq         <= 1'b0;
        end else begin
            edgecapture <= (edgecapture & ~w1c_bits) | edges;
            irq         <= |(edgecapture & irqmask);
            if (wr_en && address == ADDR_MASK) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            if (wr_en && address == ADDR_COUNT) begin
                count <= any_edge ? CNT_W'(1) : '0;
            end else if (any_edge) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !chipselect) begin
            readdata <= '0;
        end else begin
            case (address)
                ADDR_DATA:  readdata <= 32'(filtered);
                ADDR_COUNT: readdata <= 32'(count);
                ADDR_MASK:  readdata <= 32'(irqmask);
                default:    readdata <= 32'(edgecapture);
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_jsv_pio_in_edge.sv
// tb_jsv_pio_in_edge: vector table, directed corner sequences and randomized
// traffic checked against a delay-line reference model.
`default_nettype none

module tb_jsv_pio_in_edge;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [2:0]  in_port;
    logic [31:0] rd_main, rd_db, rd_any;
    logic        irq_main, irq_db, irq_any;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jsv_pio_in_edge #(.WIDTH(3), .DEBOUNCE(0), .EDGE_TYPE(0), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_main), .irq(irq_main));

    jsv_pio_in_edge #(.WIDTH(3), .DEBOUNCE(4), .EDGE_TYPE(0), .CNT_W(16)) dut_db (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_db), .irq(irq_db));

    jsv_pio_in_edge #(.WIDTH(3), .DEBOUNCE(0), .EDGE_TYPE(2), .CNT_W(4)) dut_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_any), .irq(irq_any));

    // Reference model for the main instance: the input history gives the filtered
    // value (three edges of delay), register behaviour follows the register-map rules.
    logic [2:0]  hist [0:3];
    logic [2:0]  m_ec, m_mask;
    logic [15:0] m_cnt;
    logic [31:0] m_rd;
    logic        m_irq;
    logic [2:0]  m_f_now, m_edge;
    logic        m_wr;

    assign m_f_now = hist[2];
    assign m_edge  = hist[2] & ~hist[3];
    assign m_wr    = chipselect & ~write_n;

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) hist[k] <= 3'b000;
            m_ec   <= '0;
            m_mask <= '0;
            m_cnt  <= '0;
            m_rd   <= '0;
            m_irq  <= 1'b0;
        end else begin
            hist[0] <= in_port;
            for (int k = 1; k < 4; k++) hist[k] <= hist[k-1];
            m_irq <= |(m_ec & m_mask);
            m_ec  <= (m_ec & ~((m_wr && address == 2'd3) ? writedata[2:0] : 3'b000)) | m_edge;
            if (m_wr && address == 2'd2) m_mask <= writedata[2:0];
            if (m_wr && address == 2'd1) m_cnt <= (m_edge != 0) ? 16'd1 : 16'd0;
            else if (m_edge != 0)        m_cnt <= m_cnt + 16'd1;
            if (!chipselect)             m_rd <= '0;
            else case (address)
                2'd0:    m_rd <= {29'd0, m_f_now};
                2'd1:    m_rd <= {16'd0, m_cnt};
                2'd2:    m_rd <= {29'd0, m_mask};
                default: m_rd <= {29'd0, m_ec};
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic cs, input logic wn, input logic [1:0] a,
                         input logic [31:0] wd, input logic [2:0] inp);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        in_port    = inp;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] inp);
        reset = 1'b1;
        cycle(0, 1, 0, 0, inp);
        cycle(0, 1, 0, 0, inp);
        reset = 1'b0;
    endtask

    typedef struct {
        logic        cs;
        logic        wn;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [2:0]  inp;
        logic [31:0] rd;
        logic        irq;
    } vec_t;

    vec_t tbl [21];

    initial begin
        logic [2:0] v;
        logic       seen;

        tbl[0]  = '{1, 1, 3, 0, 3'b111, 0, 0};
        tbl[1]  = '{1, 1, 0, 0, 3'b111, 0, 0};
        tbl[2]  = '{1, 1, 0, 0, 3'b111, 0, 0};
        tbl[3]  = '{1, 1, 0, 0, 3'b111, 7, 0};
        tbl[4]  = '{1, 1, 3, 0, 3'b111, 7, 0};
        tbl[5]  = '{1, 0, 3, 7, 3'b111, 7, 0};
        tbl[6]  = '{1, 1, 3, 0, 3'b111, 0, 0};
        tbl[7]  = '{1, 0, 2, 2, 3'b111, 0, 0};
        tbl[8]  = '{1, 1, 2, 0, 3'b000, 2, 0};
        tbl[9]  = '{0, 1, 0, 0, 3'b000, 0, 0};
        tbl[10] = '{0, 1, 0, 0, 3'b000, 0, 0};
        tbl[11] = '{0, 1, 0, 0, 3'b010, 0, 0};
        tbl[12] = '{1, 1, 3, 0, 3'b010, 0, 0};
        tbl[13] = '{1, 1, 3, 0, 3'b010, 0, 0};
        tbl[14] = '{1, 1, 3, 0, 3'b010, 0, 0};
        tbl[15] = '{1, 1, 3, 0, 3'b010, 2, 1};
        tbl[16] = '{1, 0, 3, 2, 3'b010, 2, 1};
        tbl[17] = '{1, 1, 3, 0, 3'b010, 0, 0};
        tbl[18] = '{1, 1, 1, 0, 3'b010, 2, 0};
        tbl[19] = '{1, 0, 1, 0, 3'b010, 2, 0};
        tbl[20] = '{1, 1, 1, 0, 3'b010, 0, 0};

        // Reset with the inputs high, then the vector table (startup capture, IRQ, W1C, count clear)
        do_reset(3'b111);
        chk("reset_readdata", rd_main, 32'd0);
        chk("reset_irq", {31'd0, irq_main}, 32'd0);
        for (int i = 0; i < 21; i++) begin
            cycle(tbl[i].cs, tbl[i].wn, tbl[i].addr, tbl[i].wd, tbl[i].inp);
            chk($sformatf("vec%0d_readdata", i), rd_main, tbl[i].rd);
            chk($sformatf("vec%0d_irq", i), {31'd0, irq_main}, {31'd0, tbl[i].irq});
        end

        // W1C colliding with a new edge on the same bit, count clear colliding with an edge
        do_reset(3'b000);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 3'b000);
        cycle(0, 1, 0, 0, 3'b001);
        cycle(0, 1, 0, 0, 3'b001);
        cycle(0, 1, 0, 0, 3'b001);
        cycle(1, 0, 3, 32'h1, 3'b001);
        cycle(1, 1, 3, 0, 3'b001);
        chk("collision_w1c", rd_main, 32'h1);
        cycle(1, 1, 1, 0, 3'b001);
        chk("collision_cnt_before", rd_main, 32'h1);
        cycle(0, 1, 0, 0, 3'b011);
        cycle(0, 1, 0, 0, 3'b011);
        cycle(0, 1, 0, 0, 3'b011);
        cycle(1, 0, 1, 0, 3'b011);
        cycle(1, 1, 1, 0, 3'b011);
        chk("collision_cnt_clear", rd_main, 32'h1);

        // Masked edges on all bits, then unmask bit 2
        do_reset(3'b000);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 3'b000);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, 3'b111);
        cycle(1, 1, 3, 0, 3'b111);
        chk("masked_edgecapture", rd_main, 32'h7);
        chk("masked_irq", {31'd0, irq_main}, 32'd0);
        cycle(1, 0, 2, 32'h4, 3'b111);
        chk("unmask_irq_lag", {31'd0, irq_main}, 32'd0);
        cycle(0, 1, 0, 0, 3'b111);
        chk("unmask_irq", {31'd0, irq_main}, 32'd1);

        // Debounce: a 3-cycle glitch is rejected, a 6-cycle pulse is accepted once
        do_reset(3'b000);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 3'b000);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0, 0, 3'b001);
            seen = seen | rd_db[0];
        end
        for (int i = 0; i < 12; i++) begin
            cycle(1, 1, 0, 0, 3'b000);
            seen = seen | rd_db[0];
        end
        chk("db_glitch_data", {31'd0, seen}, 32'd0);
        cycle(1, 1, 1, 0, 3'b000);
        chk("db_glitch_count", rd_db, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle(1, 1, 0, 0, 3'b001);
            seen = seen | rd_db[0];
        end
        for (int i = 0; i < 14; i++) begin
            cycle(1, 1, 0, 0, 3'b000);
            seen = seen | rd_db[0];
        end
        chk("db_pulse_data", {31'd0, seen}, 32'd1);
        cycle(1, 1, 1, 0, 3'b000);
        chk("db_pulse_count", rd_db, 32'd1);

        // Any-edge counting with a 4-bit counter: 16 events wrap to 0, one more gives 1
        do_reset(3'b000);
        v = 3'b000;
        for (int i = 0; i < 16; i++) begin
            v = v ^ 3'b100;
            cycle(0, 1, 0, 0, v);
            cycle(0, 1, 0, 0, v);
        end
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, v);
        cycle(1, 1, 1, 0, v);
        chk("wrap_count_zero", rd_any, 32'd0);
        v = v ^ 3'b100;
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, v);
        cycle(1, 1, 1, 0, v);
        chk("wrap_count_one", rd_any, 32'd1);
        cycle(1, 1, 3, 0, v);
        chk("any_edgecapture", rd_any, 32'h4);

        // Randomized traffic on the main instance against the reference model
        do_reset(3'($urandom));
        v = 3'b000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) v = 3'($urandom);
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                  2'($urandom), $urandom, v);
            chk("rand_readdata", rd_main, m_rd);
            chk("rand_irq", {31'd0, irq_main}, {31'd0, m_irq});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
